// File: rtl/arbitro_vc_d_if.sv
// FIFO-side handshake bundle: VC FIFO heads/flags in, D FIFO push strobes out.
interface arbitro_vc_d_if #(parameter int DATA_W = 6);
  logic              empty_VC0, empty_VC1;
  logic [DATA_W-1:0] data_VC0, data_VC1;
  logic              almost_full_D0, almost_full_D1;
  logic              pop_VC0, pop_VC1;
  logic              push_D0, push_D1;
  logic [DATA_W-1:0] data_out;

  // master: the arbiter; slave: the FIFO fabric around it
  modport master (
    input  empty_VC0, empty_VC1, data_VC0, data_VC1, almost_full_D0, almost_full_D1,
    output pop_VC0, pop_VC1, push_D0, push_D1, data_out
  );
  modport slave (
    output empty_VC0, empty_VC1, data_VC0, data_VC1, almost_full_D0, almost_full_D1,
    input  pop_VC0, pop_VC1, push_D0, push_D1, data_out
  );
endinterface

// File: rtl/arbitro_vc_d.sv
// Two-VC to two-D strict-priority arbiter: pops a VC head, pushes it one cycle later
// to the D FIFO selected by data bit 4.
module arbitro_vc_d #(
  parameter int DATA_W = 6,
  parameter int TH_W   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              init,
  input  logic [TH_W-1:0]   umbral_VCs_in,
  input  logic [TH_W-1:0]   umbral_Ds_in,
  input  logic              error_in,
  arbitro_vc_d_if.master    fifo,
  output logic [TH_W-1:0]   umbral_VCs,
  output logic [TH_W-1:0]   umbral_Ds,
  output logic              active_out,
  output logic              idle_out,
  output logic              error_out,
  output logic [2:0]        state
);

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_INIT   = 3'd1,
    ST_IDLE   = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_ERROR  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic              push0_q, push1_q;
  logic [DATA_W-1:0] data_q;
  logic              elig0, elig1, pop0, pop1, push_pend;

  // Destination almost_full only gates the pop; the in-flight word relies on the
  // D threshold leaving one spare slot.
  assign elig0 = !fifo.empty_VC0 &&
                 !(fifo.data_VC0[4] ? fifo.almost_full_D1 : fifo.almost_full_D0);
  assign elig1 = !fifo.empty_VC1 &&
                 !(fifo.data_VC1[4] ? fifo.almost_full_D1 : fifo.almost_full_D0);
  assign pop0  = (state_q == ST_ACTIVE) && elig0;
  assign pop1  = (state_q == ST_ACTIVE) && !elig0 && elig1;
  assign push_pend = push0_q || push1_q;

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_RESET;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RESET:  if (init) state_d = ST_INIT;
      ST_INIT:   if (!init) state_d = ST_IDLE;
      ST_IDLE: begin
        if (init)                                  state_d = ST_INIT;
        else if (!fifo.empty_VC0 || !fifo.empty_VC1) state_d = ST_ACTIVE;
      end
      ST_ACTIVE: if (fifo.empty_VC0 && fifo.empty_VC1 && !push_pend) state_d = ST_IDLE;
      ST_ERROR:  state_d = ST_ERROR;
      default:   state_d = ST_RESET;
    endcase
    // error beats every other transition once out of RESET
    if (error_in && (state_q == ST_INIT || state_q == ST_IDLE ||
                     state_q == ST_ACTIVE || state_q == ST_ERROR))
      state_d = ST_ERROR;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      push0_q <= 1'b0;
      push1_q <= 1'b0;
      data_q  <= '0;
    end else begin
      push0_q <= (pop0 && !fifo.data_VC0[4]) || (pop1 && !fifo.data_VC1[4]);
      push1_q <= (pop0 &&  fifo.data_VC0[4]) || (pop1 &&  fifo.data_VC1[4]);
      if (pop0)      data_q <= fifo.data_VC0;
      else if (pop1) data_q <= fifo.data_VC1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      umbral_VCs <= '0;
      umbral_Ds  <= '0;
    end else if (state_q == ST_INIT && init) begin
      umbral_VCs <= umbral_VCs_in;
      umbral_Ds  <= umbral_Ds_in;
    end
  end

  assign fifo.pop_VC0  = pop0;
  assign fifo.pop_VC1  = pop1;
  assign fifo.push_D0  = push0_q;
  assign fifo.push_D1  = push1_q;
  assign fifo.data_out = data_q;

  assign active_out = (state_q == ST_ACTIVE);
  assign idle_out   = (state_q == ST_IDLE);
  assign error_out  = (state_q == ST_ERROR);
  assign state      = state_q;

endmodule

// File: tb/tb_arbitro_vc_d.sv
// Directed bench for arbitro_vc_d: FIFO flags/heads driven by hand, outputs
// compared against hand-computed values 1 time unit after each rising edge.
module tb_arbitro_vc_d;
  logic       clk = 1'b0;
  logic       reset, init, error_in;
  logic [3:0] umbral_VCs_in, umbral_Ds_in, umbral_VCs, umbral_Ds;
  logic       active_out, idle_out, error_out;
  logic [2:0] state;
  int         checks = 0;
  int         errors = 0;

  arbitro_vc_d_if fifo_if();

  arbitro_vc_d dut (
    .clk(clk), .reset(reset), .init(init),
    .umbral_VCs_in(umbral_VCs_in), .umbral_Ds_in(umbral_Ds_in),
    .error_in(error_in), .fifo(fifo_if.master),
    .umbral_VCs(umbral_VCs), .umbral_Ds(umbral_Ds),
    .active_out(active_out), .idle_out(idle_out), .error_out(error_out),
    .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_vc(input logic e0, input logic [5:0] d0, input logic e1, input logic [5:0] d1);
    fifo_if.empty_VC0 = e0; fifo_if.data_VC0 = d0;
    fifo_if.empty_VC1 = e1; fifo_if.data_VC1 = d1;
  endtask

  task automatic chk_xfer(input string tag, input logic p0, input logic p1, input logic [5:0] d);
    chk({tag, "_push_D0"}, {7'd0, fifo_if.push_D0}, {7'd0, p0});
    chk({tag, "_push_D1"}, {7'd0, fifo_if.push_D1}, {7'd0, p1});
    chk({tag, "_data"},    {2'd0, fifo_if.data_out}, {2'd0, d});
  endtask

  task automatic chk_pop(input string tag, input logic p0, input logic p1);
    chk({tag, "_pop_VC0"}, {7'd0, fifo_if.pop_VC0}, {7'd0, p0});
    chk({tag, "_pop_VC1"}, {7'd0, fifo_if.pop_VC1}, {7'd0, p1});
  endtask

  initial begin
    reset = 1'b1; init = 1'b0; error_in = 1'b0;
    umbral_VCs_in = 4'd0; umbral_Ds_in = 4'd0;
    set_vc(1'b1, 6'h00, 1'b1, 6'h00);
    fifo_if.almost_full_D0 = 1'b0; fifo_if.almost_full_D1 = 1'b0;
    step();
    // reset state
    chk("rst_state", {5'd0, state}, 8'd0);
    chk("rst_flags", {5'd0, active_out, idle_out, error_out}, 8'd0);
    chk_xfer("rst", 1'b0, 1'b0, 6'h00);
    chk("rst_umbral", {umbral_VCs, umbral_Ds}, 8'h00);

    // configuration: two init cycles, threshold latched while in INIT
    reset = 1'b0; init = 1'b1; umbral_VCs_in = 4'd3; umbral_Ds_in = 4'd2;
    step();
    chk("cfg_state_init", {5'd0, state}, 8'd1);
    step();
    chk("cfg_state_init2", {5'd0, state}, 8'd1);
    chk("cfg_umbral", {umbral_VCs, umbral_Ds}, 8'h32);
    init = 1'b0; umbral_VCs_in = 4'd9; umbral_Ds_in = 4'd9;
    step();
    chk("cfg_state_idle", {5'd0, state}, 8'd2);
    chk("cfg_idle_out", {7'd0, idle_out}, 8'd1);
    chk("cfg_umbral_hold", {umbral_VCs, umbral_Ds}, 8'h32);

    // VC0 holds 0x05 then 0x15: back-to-back pops, pushes to D0 then D1
    set_vc(1'b0, 6'h05, 1'b1, 6'h00);
    #1 chk_pop("b2b_idle", 1'b0, 1'b0);
    step();
    chk("b2b_active", {5'd0, state}, 8'd3);
    chk_pop("b2b_pop1", 1'b1, 1'b0);
    step();
    chk_xfer("b2b_x1", 1'b1, 1'b0, 6'h05);
    set_vc(1'b0, 6'h15, 1'b1, 6'h00);
    #1 chk_pop("b2b_pop2", 1'b1, 1'b0);
    step();
    chk_xfer("b2b_x2", 1'b0, 1'b1, 6'h15);
    set_vc(1'b1, 6'h15, 1'b1, 6'h00);
    #1 chk_pop("b2b_nopop", 1'b0, 1'b0);
    step();
    chk_xfer("b2b_hold", 1'b0, 1'b0, 6'h15);
    chk("b2b_still_active", {5'd0, state}, 8'd3);
    step();
    chk("b2b_back_idle", {5'd0, state}, 8'd2);

    // both VCs loaded: VC0 first, VC1 only once VC0 is empty
    set_vc(1'b0, 6'h01, 1'b0, 6'h12);
    step();
    chk_pop("prio_vc0", 1'b1, 1'b0);
    step();
    chk_xfer("prio_x0", 1'b1, 1'b0, 6'h01);
    set_vc(1'b1, 6'h01, 1'b0, 6'h12);
    #1 chk_pop("prio_vc1", 1'b0, 1'b1);
    step();
    chk_xfer("prio_x1", 1'b0, 1'b1, 6'h12);
    set_vc(1'b1, 6'h01, 1'b1, 6'h12);
    step(); step();
    chk("prio_idle", {5'd0, state}, 8'd2);

    // VC0 blocked by almost_full_D0 does not block VC1
    fifo_if.almost_full_D0 = 1'b1;
    set_vc(1'b0, 6'h03, 1'b0, 6'h11);
    step();
    chk_pop("blk_vc1", 1'b0, 1'b1);
    step();
    chk_xfer("blk_x1", 1'b0, 1'b1, 6'h11);
    set_vc(1'b0, 6'h03, 1'b1, 6'h11);
    #1 chk_pop("blk_wait", 1'b0, 1'b0);
    fifo_if.almost_full_D0 = 1'b0;
    #1 chk_pop("blk_release", 1'b1, 1'b0);
    step();
    chk_xfer("blk_x0", 1'b1, 1'b0, 6'h03);
    set_vc(1'b1, 6'h03, 1'b1, 6'h11);
    step(); step();
    chk("blk_idle", {5'd0, state}, 8'd2);

    // error while ACTIVE: ERROR sticks through init pulses
    fifo_if.almost_full_D0 = 1'b1;
    set_vc(1'b0, 6'h03, 1'b1, 6'h00);
    step();
    chk("err_pre_active", {5'd0, state}, 8'd3);
    error_in = 1'b1;
    step();
    chk("err_state", {5'd0, state}, 8'd4);
    chk("err_flags", {5'd0, active_out, idle_out, error_out}, 8'd1);
    error_in = 1'b0; fifo_if.almost_full_D0 = 1'b0;
    #1 chk_pop("err_nopop", 1'b0, 1'b0);
    init = 1'b1;
    step(); step();
    init = 1'b0;
    step();
    chk("err_sticky", {5'd0, state}, 8'd4);
    chk_xfer("err_nopush", 1'b0, 1'b0, 6'h03);

    // reset right after a pop discards the pending push
    reset = 1'b1; set_vc(1'b1, 6'h00, 1'b1, 6'h00);
    step();
    reset = 1'b0; init = 1'b1;
    step();
    init = 1'b0;
    step();
    set_vc(1'b0, 6'h17, 1'b1, 6'h00);
    step();
    chk_pop("rstx_pop", 1'b1, 1'b0);
    reset = 1'b1;
    step();
    chk_xfer("rstx", 1'b0, 1'b0, 6'h00);
    chk("rstx_state", {5'd0, state}, 8'd0);
    chk_pop("rstx_nopop", 1'b0, 1'b0);
    chk("rstx_flags", {5'd0, active_out, idle_out, error_out}, 8'd0);
    chk("rstx_umbral", {umbral_VCs, umbral_Ds}, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/arbitro_vc_d.md
ARBITRO_VC_D -- requirements
Module: arbitro_vc_d

Interface
REQ-001 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-002 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port init  input  1  configuration request; thresholds sampled while high.
REQ-004 SHALL have port umbral_VCs_in  input  4  almost-full threshold for VC FIFOs.
REQ-005 SHALL have port umbral_Ds_in  input  4  almost-full threshold for D FIFOs.
REQ-006 SHALL have ports empty_VC0, empty_VC1  input  1 each  VC FIFO empty flags.
REQ-007 SHALL have ports data_VC0, data_VC1  input  6 each  show-ahead head of each VC FIFO, valid when matching empty low.
REQ-008 SHALL have ports almost_full_D0, almost_full_D1  input  1 each  D FIFO backpressure.
REQ-009 SHALL have port error_in  input  1  OR of all FIFO overflow/underflow flags.
REQ-010 SHALL have ports pop_VC0, pop_VC1  output  1 each  registered-decision pops.
REQ-011 SHALL have ports push_D0, push_D1  output  1 each  registered push strobes.
REQ-012 SHALL have port data_out  output  6  word pushed to D FIFO, registered.
REQ-013 SHALL have ports umbral_VCs, umbral_Ds  output  4 each  latched thresholds driven to FIFOs.
REQ-014 SHALL have ports active_out, idle_out, error_out  output  1 each  state indicators; state  output  3  encoded FSM state.

Function
REQ-015 SHALL implement FSM RESET=0, INIT=1, IDLE=2, ACTIVE=3, ERROR=4; other codes go to RESET next cycle.
REQ-016 RESET SHALL go to INIT when init=1, else stay.
REQ-017 INIT SHALL latch umbral_VCs_in/umbral_Ds_in every cycle init=1 and go to IDLE the first cycle init=0.
REQ-018 IDLE SHALL go to INIT if init=1, else to ACTIVE if empty_VC0=0 or empty_VC1=0, else stay.
REQ-019 ACTIVE SHALL go to IDLE when both VCs empty and no push pending.
REQ-020 Any state except RESET SHALL go to ERROR when error_in=1 (priority over all other transitions); ERROR held until reset.
REQ-021 Pops SHALL be asserted only in ACTIVE, combinational on current inputs, at most one per cycle.
REQ-022 Destination of a VC head SHALL be data bit 4: 0 -> D0, 1 -> D1.
REQ-023 VC is eligible when not empty and its destination almost_full is low.
REQ-024 VC0 SHALL have strict priority; VC1 pops only if VC0 is not eligible (blocked VC0 does not block VC1).
REQ-025 Popped word SHALL be registered; push_Dx and data_out asserted exactly one cycle after pop (latency 1); push and pop may overlap for back-to-back transfer, one word per cycle.
REQ-026 push_D0 and push_D1 SHALL never be high together; data_out holds last value when no push.
REQ-027 On entering ERROR, pops SHALL drop the same cycle; a word popped in the previous cycle SHALL still be pushed.
REQ-028 active_out=1 only in ACTIVE, idle_out=1 only in IDLE, error_out=1 only in ERROR.
REQ-029 D thresholds SHALL be programmed to reserve one slot for the in-flight word; block does not re-check almost_full for the pending push.

Reset
REQ-030 With reset=1 at an edge: state=RESET, all pops/pushes 0, data_out=0, umbral_VCs=0, umbral_Ds=0, active/idle/error_out=0; reset overrides mid-transfer and discards any pending push.

Verification
REQ-031 reset, init=1 with umbral_VCs_in=3, umbral_Ds_in=2 for 2 cycles, init=0 -> umbral outputs 3/2, state INIT then IDLE, idle_out=1.
REQ-032 IDLE, VC0 holds 0x05 and 0x15 -> ACTIVE next cycle; pop_VC0 two consecutive cycles; push_D0 with 0x05 then push_D1 with 0x15, each one cycle after its pop.
REQ-033 Both VCs non-empty, heads 0x01 (VC0) and 0x12 (VC1) -> VC0 popped first; VC1 popped only when VC0 empty.
REQ-034 VC0 head 0x03 with almost_full_D0=1, VC1 head 0x11 -> pop_VC1 only, push_D1 0x11; pop_VC0 after almost_full_D0 falls.
REQ-035 error_in=1 during ACTIVE -> ERROR next cycle, error_out=1, no further pops, stays through init pulses until reset.
REQ-036 reset asserted the cycle after a pop -> no push occurs, all outputs at reset values.
